// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   mult_state_e : controller states (IDLE, LOAD, ITER, DONE)
//   BOOTH_ADD/SUB: {Q[0], q_1} pair codes that select add or subtract of M
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } mult_state_e;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/subtract/keep M into A,
// then arithmetic right shift of {A, Q, q_1} by one bit.
// Ports:
//   a_in   [W+1:0] partial accumulator A (two guard bits, never overflows)
//   q_in   [W:0]   multiplier/low-product register Q
//   q1_in          previously shifted-out multiplier bit
//   m_in   [W:0]   extended multiplicand M (W+1 bits, signed view)
//   a_out, q_out, q1_out : register values after this iteration
module booth_step
  import mult_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W+1:0] a_in,
  input  logic [W:0]   q_in,
  input  logic         q1_in,
  input  logic [W:0]   m_in,
  output logic [W+1:0] a_out,
  output logic [W:0]   q_out,
  output logic         q1_out
);

  logic [W+1:0] m_sx;
  logic [W+1:0] sum;

  always_comb begin
    m_sx = {m_in[W], m_in};
    case ({q_in[0], q1_in})
      BOOTH_ADD: sum = a_in + m_sx;
      BOOTH_SUB: sum = a_in - m_sx;
      default:   sum = a_in;
    endcase
    // Arithmetic shift: A's MSB is replicated, A's LSB moves into Q.
    a_out  = {sum[W+1], sum[W+1:1]};
    q_out  = {sum[0], q_in[W:1]};
    q1_out = q_in[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// Handshake: start is sampled only in IDLE; busy is high in LOAD and ITER;
// done pulses for exactly one cycle in DONE while product is already valid.
// product holds its value until the next DONE entry (or reset).
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   start                : job request (ignored unless IDLE)
//   signed_a, signed_b   : 1 = operand is two's complement, 0 = unsigned
//   a, b       [W-1:0]   : multiplicand, multiplier
//   busy, done           : status (state-decoded, never both high)
//   product    [2W-1:0]  : result
//   dbg_state            : current controller state
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_a,
  input  logic           signed_b,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output mult_state_e    dbg_state
);

  localparam int CW = $clog2(W + 2);

  mult_state_e    state_q,   state_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic [W:0]     m_q,       m_d;
  logic [W:0]     mb_q,      mb_d;
  logic [W+1:0]   acc_q,     acc_d;
  logic [W:0]     q_q,       q_d;
  logic           q1_q,      q1_d;
  logic [2*W-1:0] product_q, product_d;

  logic [W+1:0]   step_a;
  logic [W:0]     step_q;
  logic           step_q1;

  booth_step #(.W(W)) u_step (
    .a_in   (acc_q),
    .q_in   (q_q),
    .q1_in  (q1_q),
    .m_in   (m_q),
    .a_out  (step_a),
    .q_out  (step_q),
    .q1_out (step_q1)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // One extension bit lets every mode run as a signed (W+1)-bit multiply.
          m_d     = {signed_a & a[W-1], a};
          mb_d    = {signed_b & b[W-1], b};
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d   = '0;
        q_d     = mb_q;
        q1_d    = 1'b0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        acc_d = step_a;
        q_d   = step_q;
        q1_d  = step_q1;
        // Counter runs 0..W, giving W+1 iterations over the extended multiplier.
        if (cnt_q == CW'(W)) begin
          product_d = {step_a[W-2:0], step_q};
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      product_q <= product_d;
    end
  end

  assign busy      = (state_q == LOAD) || (state_q == ITER);
  assign done      = (state_q == DONE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq at W=4 and W=32.
// Cycle numbering inside a job: cycle 0 is the cycle in which start is
// presented to an IDLE unit; LOAD is cycle 1, done is expected in cycle W+3.
module tb_booth_mult_seq;
  import mult_pkg::*;

  logic clk;
  logic reset;

  logic        start4, sa4, sb4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  prod4;
  mult_state_e st4;

  logic        start32, sa32, sb32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] prod32;
  mult_state_e st32;

  int checks;
  int failures;

  booth_mult_seq #(.W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .signed_a(sa4), .signed_b(sb4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4), .dbg_state(st4)
  );

  booth_mult_seq #(.W(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .signed_a(sa32), .signed_b(sb32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .product(prod32), .dbg_state(st32)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver: one W=4 job, observed over a bounded window
  task automatic job4(input logic sa, input logic sb, input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] p_done, output logic [7:0] p_end,
                      output int done_cyc, output int busy_cyc, output int done_cnt, output int overlap);
    done_cyc = -1; busy_cyc = 0; done_cnt = 0; overlap = 0; p_done = '0;
    sa4 = sa; sb4 = sb; a4 = a; b4 = b; start4 = 1'b1;
    tick;
    start4 = 1'b0; sa4 = ~sa; sb4 = ~sb; a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
    for (int n = 1; n <= 10; n++) begin
      if (busy4) busy_cyc++;
      if (busy4 && done4) overlap++;
      if (done4) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = n;
          p_done = prod4;
        end
      end
      tick;
    end
    p_end = prod4;
  endtask

  // driver: one W=32 job, observed over a bounded window
  task automatic job32(input logic sa, input logic sb, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] p_done, output logic [63:0] p_end,
                       output int done_cyc, output int busy_cyc, output int done_cnt, output int overlap);
    done_cyc = -1; busy_cyc = 0; done_cnt = 0; overlap = 0; p_done = '0;
    sa32 = sa; sb32 = sb; a32 = a; b32 = b; start32 = 1'b1;
    tick;
    start32 = 1'b0; sa32 = ~sa; sb32 = ~sb; a32 = $urandom; b32 = $urandom;
    for (int n = 1; n <= 38; n++) begin
      if (busy32) busy_cyc++;
      if (busy32 && done32) overlap++;
      if (done32) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = n;
          p_done = prod32;
        end
      end
      tick;
    end
    p_end = prod32;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start4 = 1'b0; sa4 = 1'b0; sb4 = 1'b0; a4 = '0; b4 = '0;
    start32 = 1'b0; sa32 = 1'b0; sb32 = 1'b0; a32 = '0; b32 = '0;
    repeat (3) tick;
    checks++; if (busy4 !== 1'b0)   begin failures++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    checks++; if (done4 !== 1'b0)   begin failures++; $display("FAIL reset_done4: got %b want 0", done4); end
    checks++; if (prod4 !== 8'h00)  begin failures++; $display("FAIL reset_prod4: got %h want 00", prod4); end
    checks++; if (st4 !== IDLE)     begin failures++; $display("FAIL reset_state4: got %0d want 0", st4); end
    checks++; if (busy32 !== 1'b0)  begin failures++; $display("FAIL reset_busy32: got %b want 0", busy32); end
    checks++; if (done32 !== 1'b0)  begin failures++; $display("FAIL reset_done32: got %b want 0", done32); end
    checks++; if (prod32 !== 64'h0) begin failures++; $display("FAIL reset_prod32: got %h want 0", prod32); end
    checks++; if (st32 !== IDLE)    begin failures++; $display("FAIL reset_state32: got %0d want 0", st32); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_w4_basic;
    logic [7:0] pd, pe;
    int dc, bc, dn, ov;
    job4(1'b1, 1'b1, 4'h3, 4'hE, pd, pe, dc, bc, dn, ov);
    checks++; if (pd !== 8'hFA) begin failures++; $display("FAIL w4_3x-2_product: got %h want fa", pd); end
    checks++; if (dc !== 7)     begin failures++; $display("FAIL w4_done_cycle: got %0d want 7", dc); end
    checks++; if (bc !== 6)     begin failures++; $display("FAIL w4_busy_cycles: got %0d want 6", bc); end
    checks++; if (dn !== 1)     begin failures++; $display("FAIL w4_done_width: got %0d want 1", dn); end
    checks++; if (ov !== 0)     begin failures++; $display("FAIL w4_busy_done_overlap: got %0d want 0", ov); end
    checks++; if (pe !== 8'hFA) begin failures++; $display("FAIL w4_product_hold: got %h want fa", pe); end
  endtask

  task automatic test_w4_modes;
    logic [7:0] pd, pe;
    int dc, bc, dn, ov;
    job4(1'b0, 1'b0, 4'hF, 4'hF, pd, pe, dc, bc, dn, ov);
    checks++; if (pd !== 8'hE1) begin failures++; $display("FAIL w4_uu_15x15: got %h want e1", pd); end
    job4(1'b1, 1'b0, 4'h8, 4'hF, pd, pe, dc, bc, dn, ov);
    checks++; if (pd !== 8'h88) begin failures++; $display("FAIL w4_su_-8x15: got %h want 88", pd); end
    checks++; if (dc !== 7)     begin failures++; $display("FAIL w4_su_done_cycle: got %0d want 7", dc); end
  endtask

  task automatic test_w32_min_neg;
    logic [63:0] pd, pe;
    int dc, bc, dn, ov;
    job32(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, pd, pe, dc, bc, dn, ov);
    checks++; if (pd !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL w32_minneg_sq: got %h want 4000000000000000", pd); end
    checks++; if (dc !== 35) begin failures++; $display("FAIL w32_done_cycle: got %0d want 35", dc); end
    checks++; if (bc !== 34) begin failures++; $display("FAIL w32_busy_cycles: got %0d want 34", bc); end
    checks++; if (dn !== 1)  begin failures++; $display("FAIL w32_done_width: got %0d want 1", dn); end
    checks++; if (ov !== 0)  begin failures++; $display("FAIL w32_busy_done_overlap: got %0d want 0", ov); end
  endtask

  task automatic test_w32_all_ones;
    logic [63:0] pd, pe;
    int dc, bc, dn, ov;
    job32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pd, pe, dc, bc, dn, ov);
    checks++; if (pd !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL w32_uu_ones: got %h want fffffffe00000001", pd); end
    job32(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pd, pe, dc, bc, dn, ov);
    checks++; if (pd !== 64'h0000_0000_0000_0001) begin failures++; $display("FAIL w32_ss_ones: got %h want 0000000000000001", pd); end
    checks++; if (pe !== 64'h0000_0000_0000_0001) begin failures++; $display("FAIL w32_ss_hold: got %h want 0000000000000001", pe); end
  endtask

  task automatic test_w32_mulhsu;
    logic [63:0] pd, pe;
    int dc, bc, dn, ov;
    job32(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, pd, pe, dc, bc, dn, ov);
    checks++; if (pd !== 64'hFFFF_FFFF_0000_0001) begin failures++; $display("FAIL w32_su_mulhsu: got %h want ffffffff00000001", pd); end
  endtask

  // start held high; each job must use the operands present at its own capture edge
  task automatic test_back_to_back;
    logic [31:0] ja [3];
    logic [31:0] jb [3];
    logic [63:0] exp_q [$];
    logic [63:0] last, want;
    int seen, unstable, k;
    ja[0] = 32'd5;          jb[0] = 32'd6;
    ja[1] = 32'h1234_5678;  jb[1] = 32'h10;
    ja[2] = 32'hFFFF_FFFE;  jb[2] = 32'd3;
    exp_q.push_back(64'd30);
    exp_q.push_back(64'h0000_0001_2345_6780);
    exp_q.push_back(64'h0000_0002_FFFF_FFFA);
    seen = 0; unstable = 0;
    sa32 = 1'b0; sb32 = 1'b0; a32 = ja[0]; b32 = jb[0]; start32 = 1'b1;
    last = prod32;
    for (int c = 0; c <= 110; c++) begin
      k = c / 36;
      if ((c % 36) == 1 && k < 3) begin
        if (k + 1 < 3) begin
          a32 = ja[k+1]; b32 = jb[k+1];
        end else begin
          start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        end
      end
      if (done32) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
        checks++;
        if (c !== 36 * seen + 35) begin failures++; $display("FAIL b2b_done_cycle job%0d: got %0d want %0d", seen, c, 36 * seen + 35); end
        checks++;
        if (prod32 !== want) begin failures++; $display("FAIL b2b_product job%0d: got %h want %h", seen, prod32, want); end
        seen++;
        last = prod32;
      end else if (prod32 !== last) begin
        unstable++;
      end
      tick;
    end
    start32 = 1'b0;
    checks++; if (seen !== 3)    begin failures++; $display("FAIL b2b_job_count: got %0d want 3", seen); end
    checks++; if (unstable !== 0) begin failures++; $display("FAIL b2b_product_stable: got %0d changes want 0", unstable); end
  endtask

  task automatic test_reset_mid_iter;
    logic [63:0] pd, pe;
    int dc, bc, dn, ov;
    sa32 = 1'b1; sb32 = 1'b1; a32 = 32'd1234; b32 = 32'd5678; start32 = 1'b1;
    tick;
    start32 = 1'b0;
    repeat (11) tick;  // now in cycle 12: ITER with counter = 10
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (busy32 !== 1'b0)  begin failures++; $display("FAIL midreset_busy: got %b want 0", busy32); end
    checks++; if (done32 !== 1'b0)  begin failures++; $display("FAIL midreset_done: got %b want 0", done32); end
    checks++; if (prod32 !== 64'h0) begin failures++; $display("FAIL midreset_prod: got %h want 0", prod32); end
    checks++; if (st32 !== IDLE)    begin failures++; $display("FAIL midreset_state: got %0d want 0", st32); end
    job32(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFB, pd, pe, dc, bc, dn, ov);
    checks++; if (pd !== 64'hFFFF_FFFF_FFFF_FFDD) begin failures++; $display("FAIL midreset_7x-5: got %h want ffffffffffffffdd", pd); end
    checks++; if (dc !== 35) begin failures++; $display("FAIL midreset_done_cycle: got %0d want 35", dc); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_w4_basic;
    test_w4_modes;
    test_w32_min_neg;
    test_w32_all_ones;
    test_w32_mulhsu;
    test_back_to_back;
    test_reset_mid_iter;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
